fifo_write_packer: RTL
======================

Name: fifo_write_packer

Overview:
Write-side stage that feeds the dual-clock FIFO.
- Accepts a narrow valid/ready byte stream with a frame-end marker and packs RATIO input beats into one wide FIFO word.
- Drives the FIFO's write_en/write_data and honours its full flag.
- Each FIFO word carries lane-occupancy and last-of-frame sideband, so the read side can unpack partial final words.
- Runs entirely in the write_clk domain.

Parameters:
IN_WIDTH, 8, width of one input beat (lane).
RATIO, 4, input beats per FIFO word; power of two, >= 2.
PAD_VALUE, 8'h00, value written into unused lanes of a partial word; IN_WIDTH bits.
LANE_W, clog2(RATIO), derived localparam; width of lane index/count field.
OUT_WIDTH, IN_WIDTH*RATIO+LANE_W+1, derived localparam; FIFO word width (set FIFO DATA_WIDTH to this).

Ports:
write_clk  in  1  write-domain clock
write_reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  upstream beat valid
in_ready  out  1  block accepts beat this cycle
in_data  in  IN_WIDTH  beat payload
in_last  in  1  beat is final beat of frame
full  in  1  FIFO full flag, write_clk domain
write_en  out  1  FIFO write strobe
write_data  out  OUT_WIDTH  FIFO word: {last, count_m1[LANE_W-1:0], lanes[IN_WIDTH*RATIO-1:0]}
words_written  out  16  count of FIFO writes; wraps modulo 2^16
frames_written  out  16  count of FIFO writes with last=1; wraps modulo 2^16

Behaviour:
Reset (async assert, sync release) clears all of the following:
- write_en=0, write_data=0.
- lane index=0, pack buffer filled with PAD_VALUE, out_pend=0.
- words_written=0, frames_written=0.
- in_ready=1 from the first cycle after reset release.

State:
- Pack buffer of RATIO lanes, with lane index 0..RATIO-1.
- One-word output register with pend flag out_pend.

Handshakes and ready rule:
- Beat accepted when in_valid && in_ready. Data transfers only on acceptance; stalled inputs must be held by upstream.
- in_ready = !out_pend || !full. Uniform rule: it does not depend on in_valid or in_last, and is combinational only from out_pend and full.

Packing:
- Accepted beat is written into lane[index]. Lane 0 occupies bits [IN_WIDTH-1:0] (little-endian by arrival).
- A word completes when the beat lands in lane RATIO-1 or has in_last=1.

On word completion (same edge as acceptance):
- Output register loads lanes; lanes above index are filled with PAD_VALUE.
- count_m1 = index of the final beat; last = in_last.
- out_pend set; lane index returns to 0; pack buffer lanes reset to PAD_VALUE.

Otherwise the lane index increments.

FIFO write side:
- write_en = out_pend && !full (combinational); write_data = output register.
- On write_en, out_pend clears, unless a new word completes on the same edge, in which case the register reloads and out_pend stays 1.
- Latency: beat that completes a word at edge N → write_en asserted in cycle after N if full=0. Sustained throughput: one FIFO word per RATIO input cycles with no full.

Boundary conditions:
- full=1 with out_pend=1: write_en=0, in_ready=0, register and write_data held stable until full drops.
- full=1 with out_pend=0: beats keep being accepted. A completing beat loads the register, after which in_ready falls.
- Single-beat frame (in_last on lane 0): count_m1=0, lanes 1..RATIO-1 = PAD_VALUE.
- in_last on lane RATIO-1: a full word with last=1; no extra pad word is produced.
- Counters increment by 1 on each write_en (frames_written only when the word's last=1) and wrap 16'hFFFF→0.
- Reset mid-frame: the partial word and the pending word are discarded; there is no flush on reset.
- full is sampled only in write_clk; the block never writes while full=1.

Test Plan:
1. Reset, then 4 beats 0x11,0x22,0x33,0x44 (last on 0x44), full=0 → one write_en cycle one cycle after the 4th accept; write_data={1,2'd3,32'h44332211}; words_written=1, frames_written=1.
2. 6-beat frame 0x01..0x06 (last on 0x06) → two writes: {0,2'd3,32'h04030201} then {1,2'd1,32'h00000605}; frames_written=1.
3. Single beat 0xAB with last, PAD_VALUE=0xFF → write_data={1,2'd0,32'hFFFFFFAB}.
4. full=1 held for 10 cycles while streaming 8 beats → first word captured, in_ready=0 and write_en=0 throughout with write_data stable. After full=0, words are written in order with no loss or duplication; in_ready recovers the same cycle full drops.
5. Continuous back-to-back stream of 64 beats, full=0 → 16 writes, one every 4 cycles, in_ready constantly 1, payload matches in order.
6. Assert write_reset_n low after 2 beats of a frame → write_en=0, in_ready=1 after release, counters 0. The next 4-beat frame is packed starting at lane 0 with no stale bytes.

Source files
------------

// File: rtl/fifo_write_packer.sv
// Write-side packer for the dual-clock FIFO: gathers RATIO narrow beats into one
// wide word that carries lane-occupancy and last-of-frame sideband.
module fifo_write_packer #(
  parameter int unsigned            IN_WIDTH  = 8,
  parameter int unsigned            RATIO     = 4,
  parameter logic [IN_WIDTH-1:0]    PAD_VALUE = '0,
  localparam int unsigned           LANE_W    = $clog2(RATIO),
  localparam int unsigned           OUT_WIDTH = IN_WIDTH * RATIO + LANE_W + 1
) (
  input  logic                 write_clk,
  input  logic                 write_reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  input  logic                 full,
  output logic                 write_en,
  output logic [OUT_WIDTH-1:0] write_data,
  output logic [15:0]          words_written,
  output logic [15:0]          frames_written
);

  typedef logic [RATIO-1:0][IN_WIDTH-1:0] lanes_t;

  lanes_t                lanes_q, lanes_d, lanes_fill;
  logic [LANE_W-1:0]     idx_q, idx_d;
  logic [OUT_WIDTH-1:0]  out_q, out_d;
  logic                  pend_q, pend_d;
  logic [15:0]           words_q, words_d;
  logic [15:0]           frames_q, frames_d;
  logic                  accept;
  logic                  complete;

  // Ready never looks at in_valid/in_last: a slot exists if the output word is empty or draining.
  assign in_ready       = !pend_q || !full;
  assign write_en       = pend_q && !full;
  assign write_data     = out_q;
  assign words_written  = words_q;
  assign frames_written = frames_q;

  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (idx_q == LANE_W'(RATIO - 1)));

  // Lanes above the current index already hold PAD_VALUE, so only the landing lane changes.
  always_comb begin
    lanes_fill         = lanes_q;
    lanes_fill[idx_q]  = in_data;

    lanes_d  = lanes_q;
    idx_d    = idx_q;
    out_d    = out_q;
    pend_d   = pend_q;
    words_d  = words_q;
    frames_d = frames_q;

    if (write_en) begin
      pend_d  = 1'b0;
      words_d = words_q + 16'd1;
      if (out_q[OUT_WIDTH-1]) begin
        frames_d = frames_q + 16'd1;
      end
    end

    // A completing beat may reload the output word on the same edge it drains.
    if (accept) begin
      if (complete) begin
        out_d   = {in_last, idx_q, lanes_fill};
        pend_d  = 1'b1;
        idx_d   = '0;
        lanes_d = {RATIO{PAD_VALUE}};
      end else begin
        lanes_d = lanes_fill;
        idx_d   = idx_q + LANE_W'(1);
      end
    end
  end

  always_ff @(posedge write_clk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      lanes_q  <= {RATIO{PAD_VALUE}};
      idx_q    <= '0;
      out_q    <= '0;
      pend_q   <= 1'b0;
      words_q  <= '0;
      frames_q <= '0;
    end else begin
      lanes_q  <= lanes_d;
      idx_q    <= idx_d;
      out_q    <= out_d;
      pend_q   <= pend_d;
      words_q  <= words_d;
      frames_q <= frames_d;
    end
  end

endmodule
